test_harness_ctrl: RTL

TEST_HARNESS_CTRL -- requirements
Module: test_harness_ctrl

---
 rtl/test_harness_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/test_harness_ctrl.sv
// rtl/test_harness_ctrl.sv - program loader, core reset sequencer and tohost monitor
//
// Loads a program word stream into instruction memory, holds the core under
// test in reset for RST_HOLD cycles, releases it and watches its store bus for
// a write to TOHOST_ADDR (pass when the stored value is 1) or a cycle timeout.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           one-cycle request to begin load/run (IDLE/DONE only)
//   s_valid/s_ready/s_data/s_last   program word stream
//   imem_we/imem_addr/imem_wdata    instruction-memory write port
//   core_rst_n                      active-low reset to the core under test
//   dmem_we/dmem_addr/dmem_wdata    core store bus (monitored)
//   busy/done/pass/timeout/load_ovf status flags
//   fail_code                       upper XLEN-1 bits of a failing tohost value
//   cycle_count                     RUN cycles elapsed
module test_harness_ctrl #(
   parameter int              XLEN           = 32,
   parameter int              IMEM_DEPTH     = 1024,
   parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h0000_1000,
   parameter logic [31:0]     TIMEOUT_CYCLES = 32'd1000,
   parameter int unsigned     RST_HOLD       = 2,
   localparam int             AW             = $clog2(IMEM_DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [XLEN-1:0] s_data,
   input  logic            s_last,
   output logic            imem_we,
   output logic [AW-1:0]   imem_addr,
   output logic [XLEN-1:0] imem_wdata,
   output logic            core_rst_n,
   input  logic            dmem_we,
   input  logic [XLEN-1:0] dmem_addr,
   input  logic [XLEN-1:0] dmem_wdata,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic            timeout,
   output logic            load_ovf,
   output logic [XLEN-2:0] fail_code,
   output logic [31:0]     cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);
   localparam logic [7:0]    HOLD_LAST = 8'(RST_HOLD - 1);

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [7:0]      hold_q, hold_d;
   logic [31:0]     cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            tmo_q, tmo_d;
   logic            ovf_q, ovf_d;
   logic [XLEN-2:0] fail_q, fail_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         hold_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         tmo_q   <= 1'b0;
         ovf_q   <= 1'b0;
         fail_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         tmo_q   <= tmo_d;
         ovf_q   <= ovf_d;
         fail_q  <= fail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      pass_d  = pass_q;
      tmo_d   = tmo_q;
      ovf_d   = ovf_q;
      fail_d  = fail_q;
      s_ready = 1'b0;
      imem_we = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_LOAD;
               addr_d  = '0;
               cnt_d   = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               tmo_d   = 1'b0;
               ovf_d   = 1'b0;
               fail_d  = '0;
            end
         end
         S_LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               imem_we = 1'b1;
               // The last memory slot ends the load even without s_last;
               // that case is flagged as an overflow.
               if (s_last || addr_q == LAST_ADDR) begin
                  state_d = S_HOLD;
                  hold_d  = '0;
                  ovf_d   = !s_last;
               end else begin
                  addr_d = addr_q + AW'(1);
               end
            end
         end
         S_HOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d = S_RUN;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 32'd1;
            // Tohost store takes priority over a coincident timeout.
            if (dmem_we && dmem_addr == TOHOST_ADDR) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               pass_d  = (dmem_wdata == XLEN'(1));
               if (dmem_wdata != XLEN'(1)) begin
                  fail_d = dmem_wdata[XLEN-1:1];
               end
            end else if (cnt_d == TIMEOUT_CYCLES) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               tmo_d   = 1'b1;
               pass_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_addr   = addr_q;
   assign imem_wdata  = s_data;
   assign core_rst_n  = (state_q == S_RUN);
   assign busy        = (state_q == S_LOAD) || (state_q == S_HOLD) || (state_q == S_RUN);
   assign done        = done_q;
   assign pass        = pass_q;
   assign timeout     = tmo_q;
   assign load_ovf    = ovf_q;
   assign fail_code   = fail_q;
   assign cycle_count = cnt_q;

endmodule
